// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares the single address/data port of a W-bit, 2**D-entry register file
//   between two requesters. Requester 0 is the core datapath and requester 1
//   is the load/debug path. The arbiter grants one access per cycle using
//   round-robin priority. A requester can lock the port for a burst of
//   back-to-back accesses, and MAX_BURST caps the length of that burst.
//
// Ports
//   CLK, RST_N             clock, asynchronous active-low reset
//   req_valid/we/lock[1:0] per-requester request, write flag and lock hint
//   req0/1_addr, wdata     per-requester address and write data
//   req_ready[1:0]         one-hot combinational grant
//   rsp_valid[1:0]         one-cycle read response pulse to the reader
//   rsp_data               registered read data (held between responses)
//   rf_write_en/addr/data_in  drive the register file port
//   rf_data_out            combinational read data from the register file
module rf_port_arbiter #(
  parameter int W         = 8,
  parameter int D         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [1:0]   req_valid,
  input  logic [1:0]   req_we,
  input  logic [1:0]   req_lock,
  input  logic [D-1:0] req0_addr,
  input  logic [D-1:0] req1_addr,
  input  logic [W-1:0] req0_wdata,
  input  logic [W-1:0] req1_wdata,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rf_write_en,
  output logic [D-1:0] rf_addr,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out
);

  localparam int CW = $clog2(MAX_BURST + 1);
  // A locked transfer that brings the count to MAX_BURST ends the burst, so
  // the burst may continue only while the count is below MAX_BURST-1.
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  // With MAX_BURST == 1 a lock could never yield a second transfer, so a lock
  // is never entered and the arbiter behaves as plain round-robin.
  localparam bit LOCK_EN = (MAX_BURST > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t         state_r;
  logic           rr_r;        // requester favoured on contention in IDLE
  logic [CW-1:0]  cnt_r;       // transfers granted so far in the current lock
  logic [1:0]     rsp_valid_r;
  logic [W-1:0]   rsp_data_r;

  logic [1:0]     grant_s;
  logic           xfer_s;
  logic           win_s;
  logic           we_s;
  logic           lock_s;
  logic [D-1:0]   addr_s;
  logic [W-1:0]   wdata_s;
  logic [W-1:0]   read_data_s;

  // Grant selection from request, state and round-robin pointer only.
  always_comb begin
    grant_s = 2'b00;
    case (state_r)
      IDLE: begin
        if (req_valid == 2'b11) begin
          grant_s = rr_r ? 2'b10 : 2'b01;
        end else begin
          grant_s = req_valid;
        end
      end
      LOCK0:   grant_s = {1'b0, req_valid[0]};
      LOCK1:   grant_s = {req_valid[1], 1'b0};
      default: grant_s = 2'b00;
    endcase
  end

  assign xfer_s = |grant_s;
  assign win_s  = grant_s[1];

  // Route the winning requester onto the register file port.
  always_comb begin
    we_s    = 1'b0;
    lock_s  = 1'b0;
    addr_s  = {D{1'b0}};
    wdata_s = {W{1'b0}};
    if (xfer_s) begin
      we_s    = req_we[win_s];
      lock_s  = req_lock[win_s];
      addr_s  = win_s ? req1_addr  : req0_addr;
      wdata_s = win_s ? req1_wdata : req0_wdata;
    end else begin
      we_s    = 1'b0;
      lock_s  = 1'b0;
      addr_s  = {D{1'b0}};
      wdata_s = {W{1'b0}};
    end
  end

  // Register 0 is a constant-zero location whatever the file returns.
  assign read_data_s = (addr_s == {D{1'b0}}) ? {W{1'b0}} : rf_data_out;

  // Arbitration FSM plus the registered read response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      rr_r        <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {W{1'b0}};
    end else begin
      rsp_valid_r <= (xfer_s && !we_s) ? grant_s : 2'b00;
      if (xfer_s && !we_s) begin
        rsp_data_r <= read_data_s;
      end

      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            rr_r <= ~win_s;
            if (LOCK_EN && lock_s) begin
              state_r <= win_s ? LOCK1 : LOCK0;
              cnt_r   <= CW'(1);
            end
          end
        end
        LOCK0, LOCK1: begin
          // In a lock state a transfer happens exactly when the owner is
          // valid; an idle owner releases the lock without a grant.
          if (xfer_s && lock_s && (cnt_r < LAST_CNT)) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            state_r <= IDLE;
            rr_r    <= (state_r == LOCK0);
            cnt_r   <= {CW{1'b0}};
          end
        end
        default: begin
          state_r <= IDLE;
          rr_r    <= 1'b0;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign req_ready   = grant_s;
  assign rf_write_en = xfer_s & we_s;
  assign rf_addr     = addr_s;
  assign rf_data_in  = wdata_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural 8x16 register file.
module tb_rf_port_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [1:0] req_valid;
  logic [1:0] req_we;
  logic [1:0] req_lock;
  logic [3:0] req0_addr;
  logic [3:0] req1_addr;
  logic [7:0] req0_wdata;
  logic [7:0] req1_wdata;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       rf_write_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_data_in;
  logic [7:0] rf_data_out;

  int checks   = 0;
  int failures = 0;

  logic       preload;
  logic [7:0] mem [16];

  rf_port_arbiter #(.W(8), .D(4), .MAX_BURST(4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req0_addr   (req0_addr),
    .req1_addr   (req1_addr),
    .req0_wdata  (req0_wdata),
    .req1_wdata  (req1_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rf_write_en (rf_write_en),
    .rf_addr     (rf_addr),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: location 0 holds junk (0xEE) to expose a missing
  // zero-forcing on reads, and writes to location 0 are dropped.
  assign rf_data_out = mem[rf_addr];
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hEE;
      mem[3] <= 8'h5A;
    end else if (rf_write_en && rf_addr != 4'd0) begin
      mem[rf_addr] <= rf_data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
    req_valid  = v;
    req_we     = we;
    req_lock   = lk;
    req0_addr  = a0;
    req1_addr  = a1;
    req0_wdata = d0;
    req1_wdata = d1;
  endtask

  logic [1:0] exp_g [6];

  initial begin
    RST_N   = 1'b0;
    preload = 1'b1;
    set_in(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we", rf_write_en, 1'b0);
    chk("rst_addr", rf_addr, 4'd0);
    chk("rst_din", rf_data_in, 8'h00);

    // Single read by req0 of addr 3
    @(negedge CLK);
    RST_N   = 1'b1;
    preload = 1'b0;
    set_in(2'b01, 2'b00, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    #1;
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_we", rf_write_en, 1'b0);
    chk("t1_addr", rf_addr, 4'd3);
    @(posedge CLK); #1;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 8'h5A);

    // Single read by req1 of addr 3; pointer returns to req0
    @(negedge CLK);
    set_in(2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    #1;
    chk("t1b_ready", req_ready, 2'b10);
    chk("t1b_addr", rf_addr, 4'd3);
    @(posedge CLK); #1;
    chk("t1b_rsp_valid", rsp_valid, 2'b10);
    chk("t1b_rsp_data", rsp_data, 8'h5A);

    // Contended writes alternate
    @(negedge CLK);
    set_in(2'b11, 2'b11, 2'b00, 4'd1, 4'd2, 8'h11, 8'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_we", rf_write_en, 1'b1);
      chk("t2_addr", rf_addr, (i % 2 == 0) ? 4'd1 : 4'd2);
      chk("t2_din", rf_data_in, (i % 2 == 0) ? 8'h11 : 8'h22);
      @(posedge CLK); #1;
      chk("t2_no_rsp", rsp_valid, 2'b00);
      @(negedge CLK);
    end

    // req0 reads addr 1, pointer moves to req1
    set_in(2'b01, 2'b00, 2'b00, 4'd1, 4'd0, 8'h00, 8'h00);
    #1;
    chk("t2b_ready", req_ready, 2'b01);
    @(posedge CLK); #1;
    chk("t2b_rsp_valid", rsp_valid, 2'b01);
    chk("t2b_rsp_data", rsp_data, 8'h11);
    @(negedge CLK);

    // req1 locked burst capped at 4 while req0 waits
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10;
    exp_g[3] = 2'b10; exp_g[4] = 2'b01; exp_g[5] = 2'b10;
    set_in(2'b11, 2'b00, 2'b10, 4'd1, 4'd2, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_ready", req_ready, exp_g[i]);
      @(posedge CLK); #1;
      chk("t3_rsp_valid", rsp_valid, exp_g[i]);
      chk("t3_rsp_data", rsp_data, (exp_g[i] == 2'b10) ? 8'h22 : 8'h11);
      @(negedge CLK);
    end

    // Locked req1 (LOCK1, count 1) drops valid: no grant, then req0 wins
    set_in(2'b01, 2'b00, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    #1;
    chk("t6_drop_ready", req_ready, 2'b00);
    @(posedge CLK); #1;
    chk("t6_drop_rsp", rsp_valid, 2'b00);
    chk("t6_hold_data", rsp_data, 8'h22);
    @(negedge CLK); #1;
    chk("t6_next_ready", req_ready, 2'b01);
    @(posedge CLK); #1;
    chk("t6_rsp_valid", rsp_valid, 2'b01);
    chk("t6_rsp_data", rsp_data, 8'h11);

    // Write then immediate read of addr 5
    @(negedge CLK);
    set_in(2'b01, 2'b01, 2'b00, 4'd5, 4'd0, 8'hC3, 8'h00);
    #1;
    chk("t4_w_ready", req_ready, 2'b01);
    chk("t4_w_we", rf_write_en, 1'b1);
    chk("t4_w_addr", rf_addr, 4'd5);
    chk("t4_w_din", rf_data_in, 8'hC3);
    @(posedge CLK); #1;
    chk("t4_w_no_rsp", rsp_valid, 2'b00);
    @(negedge CLK);
    set_in(2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
    #1;
    chk("t4_r_ready", req_ready, 2'b01);
    @(posedge CLK); #1;
    chk("t4_r_rsp_valid", rsp_valid, 2'b01);
    chk("t4_r_rsp_data", rsp_data, 8'hC3);

    // Write 0xFF to addr 0, then read addr 0 returns zero
    @(negedge CLK);
    set_in(2'b01, 2'b01, 2'b00, 4'd0, 4'd0, 8'hFF, 8'h00);
    #1;
    chk("t4_w0_we", rf_write_en, 1'b1);
    chk("t4_w0_ready", req_ready, 2'b01);
    @(posedge CLK);
    @(negedge CLK);
    set_in(2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("t4_r0_addr", rf_addr, 4'd0);
    @(posedge CLK); #1;
    chk("t4_r0_rsp_valid", rsp_valid, 2'b01);
    chk("t4_r0_rsp_data", rsp_data, 8'h00);

    // Reset asserted mid-lock (LOCK1, count 2) with a read in flight
    @(negedge CLK);
    set_in(2'b10, 2'b00, 2'b10, 4'd0, 4'd2, 8'h00, 8'h00);
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("t5_pre_rsp", rsp_valid, 2'b10);
    @(negedge CLK); #1;
    chk("t5_inflight_ready", req_ready, 2'b10);
    #1;
    RST_N = 1'b0;
    #1;
    chk("t5_rst_rsp_valid", rsp_valid, 2'b00);
    chk("t5_rst_rsp_data", rsp_data, 8'h00);
    @(posedge CLK); #1;
    chk("t5_rst_edge_rsp", rsp_valid, 2'b00);
    @(negedge CLK);
    RST_N = 1'b1;
    set_in(2'b11, 2'b00, 2'b00, 4'd3, 4'd2, 8'h00, 8'h00);
    #1;
    chk("t5_post_ready", req_ready, 2'b01);
    @(posedge CLK); #1;
    chk("t5_post_rsp_valid", rsp_valid, 2'b01);
    chk("t5_post_rsp_data", rsp_data, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
